// File: rtl/mips_mdu_pkg.sv
// Shared types for the MIPS multiply/divide unit: op encodings, FSM states
// and small op-decode helpers.
package mips_mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_t;

  // Bit 0 clear selects the signed flavour (MULT, DIV).
  function automatic logic op_is_signed(mdu_op_t o);
    return ~o[0];
  endfunction

  // Bit 1 set selects a divide (DIV, DIVU).
  function automatic logic op_is_div(mdu_op_t o);
    return o[1];
  endfunction

endpackage

// File: rtl/mips_mdu_negate.sv
// Conditional two's complement: out = neg ? -in : in.
module mips_mdu_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_val,
  input  logic         neg,
  output logic [W-1:0] out_val
);

  // Negate by invert-plus-one when requested, pass through otherwise.
  always_comb begin
    out_val = neg ? (~in_val + W'(1)) : in_val;
  end

endmodule

// File: rtl/mips_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO. Operands are
// reduced to magnitudes at launch, iterated unsigned for WIDTH cycles
// (shift-add multiply / restoring divide), then sign-corrected in FIX.
module mips_mdu
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH;

  mdu_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  mdu_op_t          op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // |a| for multiply, |b| for divide
  logic [AW-1:0]    acc_q, acc_d;     // {partial hi / remainder, multiplier / dividend->quotient}
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] araw_q, araw_d;   // raw dividend, returned in HI on divide-by-zero
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  mdu_op_t          op_in;
  logic             a_neg, b_neg, last;
  logic [WIDTH-1:0] a_abs, b_abs, quo_fix, rem_fix;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic             div_ok;
  logic [AW-1:0]    mul_next, div_next;

  assign op_in = mdu_op_t'(op);
  assign a_neg = op_is_signed(op_in) & a[WIDTH-1];
  assign b_neg = op_is_signed(op_in) & b[WIDTH-1];
  assign last  = (cnt_q == CW'(WIDTH - 1));

  mips_mdu_negate #(.W(WIDTH)) u_abs_a (.in_val(a), .neg(a_neg), .out_val(a_abs));
  mips_mdu_negate #(.W(WIDTH)) u_abs_b (.in_val(b), .neg(b_neg), .out_val(b_abs));
  mips_mdu_negate #(.W(AW))    u_prod  (.in_val(acc_q), .neg(neg_res_q), .out_val(prod_fix));
  mips_mdu_negate #(.W(WIDTH)) u_quo   (.in_val(acc_q[WIDTH-1:0]), .neg(neg_res_q), .out_val(quo_fix));
  mips_mdu_negate #(.W(WIDTH)) u_rem   (.in_val(acc_q[AW-1:WIDTH]), .neg(neg_rem_q), .out_val(rem_fix));

  // One iteration step for each algorithm; the FSM picks which one lands.
  always_comb begin
    // Shift-add: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    mul_sum   = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    // Restoring: shift next dividend bit into the remainder, keep the subtraction if it did not borrow.
    div_shift = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_trial[WIDTH];
    div_next  = {(div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ok};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: IDLE -> CALC on start, WIDTH iterations, one FIX cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last)  state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy covers the iteration cycles only; done is the registered FIX pulse.
  always_comb begin
    busy = (state_q == CALC);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // Datapath next values: launch latch, iteration, result write-back, MTHI/MTLO.
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    araw_d    = araw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op_in;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = op_is_div(op_in) & (b == '0);
          araw_d    = a;
          if (op_is_div(op_in)) begin
            opnd_d = b_abs;
            acc_d  = {{WIDTH{1'b0}}, a_abs};
          end else begin
            opnd_d = a_abs;
            acc_d  = {{WIDTH{1'b0}}, b_abs};
          end
        end else begin
          // MTHI/MTLO only land when no operation is being launched.
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      CALC: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        cnt_d = last ? '0 : cnt_q + CW'(1);
      end
      FIX: begin
        done_d = 1'b1;
        if (op_is_div(op_q)) begin
          if (div0_q) begin
            lo_d = '1;
            hi_d = araw_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= MDU_MULT;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      araw_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      araw_q    <= araw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_mips_mdu.sv
// Scoreboard bench for mips_mdu: stimulus pushes expected HI/LO, a monitor
// pops and compares on every done pulse.
module tb_mips_mdu;

  localparam int W = 32;

  logic         clk, rst_n, start, hi_we, lo_we, busy, done;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata, hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   nid    = 0;

  mips_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk($sformatf("hi#%0d", e.id), {32'd0, hi}, {32'd0, e.hi});
        chk($sformatf("lo#%0d", e.id), {32'd0, lo}, {32'd0, e.lo});
      end
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input bit push, input bit we);
    start = 1'b1; op = o; a = aa; b = bb; hi_we = we; wdata = 32'h0BADF00D;
    if (push) begin
      sb.push_back('{hi: eh, lo: el, id: nid});
      nid++;
    end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
  endtask

  // Waits for done, checking latency and busy width; optionally pokes start/hi_we mid-op.
  task automatic wait_done(input bit poke, input logic [W-1:0] hold_hi);
    int k, bcnt;
    k = 0;
    bcnt = busy ? 1 : 0;
    while (k < W + 6) begin
      @(negedge clk);
      k++;
      if (poke && (k == 5 || k == 10)) begin
        start = 1'b1; op = 2'b11; a = 32'h99; b = 32'h3; hi_we = 1'b1; wdata = 32'hDEADBEEF;
      end
      if (poke && (k == 6 || k == 11)) begin
        start = 1'b0; hi_we = 1'b0;
        chk("hi_we_dropped", {32'd0, hi}, {32'd0, hold_hi});
      end
      if (done) break;
      if (busy) bcnt++;
    end
    chk("latency", 64'(k), 64'(W + 1));
    chk("busy_cycles", 64'(bcnt), 64'(W));
  endtask

  logic [1:0]   tv_op[8];
  logic [W-1:0] tv_a[8], tv_b[8], tv_h[8], tv_l[8];

  initial begin
    tv_op = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10};
    tv_a  = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'h7, 32'h7, 32'h80000000, 32'h1234, 32'hFFFFFFFB};
    tv_b  = '{32'h5, 32'h80000000, 32'h2, 32'h2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h0};
    tv_h  = '{32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 32'h1234, 32'hFFFFFFFB};
    tv_l  = '{32'hFFFFFFF1, 32'h0, 32'hFFFFFFFD, 32'h3, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle MTHI / MTLO / both.
    hi_we = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'hAAAA5555});
    chk("mthi_lo", {32'd0, lo}, 64'd0);
    lo_we = 1'b1; wdata = 32'h1;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", {32'd0, lo}, 64'd1);
    chk("mtlo_hi", {32'd0, hi}, {32'd0, 32'hAAAA5555});
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h13579BDF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mtboth_hi", {32'd0, hi}, {32'd0, 32'h13579BDF});
    chk("mtboth_lo", {32'd0, lo}, {32'd0, 32'h13579BDF});

    // MULTU max*max with MTHI in the launch cycle (must be dropped).
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b1);
    chk("start_hi_we_dropped", {32'd0, hi}, {32'd0, 32'h13579BDF});
    wait_done(1'b0, '0);
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Directed table, each launched in the previous op's done cycle.
    for (int i = 0; i < 8; i++) begin
      issue(tv_op[i], tv_a[i], tv_b[i], tv_h[i], tv_l[i], 1'b1, 1'b0);
      wait_done(1'b0, '0);
    end

    // Back-to-back MULTU 6*7 with ignored start/MTHI pokes mid-operation.
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 1'b0);
    wait_done(1'b1, 32'hFFFFFFFB);

    // Abort a MULT with reset mid-operation, then run a clean DIVU.
    @(negedge clk);
    issue(2'b00, 32'd3, 32'd5, '0, '0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0);
    wait_done(1'b0, '0);
    @(negedge clk); @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
